// File: rtl/thread_manager.sv
// thread_manager: central thread-control issuer.
//   - Boots thread 0 with a single init command right after reset release.
//   - Serialises thread-op requests (spawn/sleep/wake/kill). Each accepted op
//     drives one registered command pulse, then one response pulse.
//     Throughput is one op every 3 cycles.
//   - Allocates a free thread ID on spawn.
//   - Runs a round-robin scheduler over the threads that are valid & running.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake
//   req_op                      op code: 00 spawn, 01 sleep, 10 wake, 11 kill
//   req_act_trd, req_obj_trd    action and target thread (obj ignored on spawn)
//   req_pc                      start PC for spawn
//   trd_valid/running/error     per-thread CSR status (error is combinational)
//   cmd_init/slp/wake/kill      one-hot, one-cycle command pulses
//   cmd_obj_trd/act_trd/pc      command bus payload
//   rsp_valid/rsp_trd/rsp_fail  completion pulse, thread ID and fail flag
//   sched_en                    advance the scheduler this cycle
//   cur_trd/cur_vld             scheduled thread and "any thread runnable"
//
// Optional feature (macro THREAD_MGR_RR_ALLOC_EN):
//   defined   -> spawn searches round-robin from (last allocated + 1)
//   undefined -> spawn takes the lowest free index; no pointer register
module thread_manager #(
  parameter int          NUM_TRD  = 8,
  parameter int          TRD_W    = 3,
  parameter logic [31:0] START_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [TRD_W-1:0]   req_act_trd,
  input  logic [TRD_W-1:0]   req_obj_trd,
  input  logic [31:0]        req_pc,
  input  logic [NUM_TRD-1:0] trd_valid,
  input  logic [NUM_TRD-1:0] trd_running,
  input  logic [NUM_TRD-1:0] trd_error,
  output logic               cmd_init,
  output logic               cmd_slp,
  output logic               cmd_wake,
  output logic               cmd_kill,
  output logic [TRD_W-1:0]   cmd_obj_trd,
  output logic [TRD_W-1:0]   cmd_act_trd,
  output logic [31:0]        cmd_pc,
  output logic               rsp_valid,
  output logic [TRD_W-1:0]   rsp_trd,
  output logic               rsp_fail,
  input  logic               sched_en,
  output logic [TRD_W-1:0]   cur_trd,
  output logic               cur_vld
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OP_SPAWN = 2'b00;
  localparam logic [1:0] OP_SLP   = 2'b01;
  localparam logic [1:0] OP_WAKE  = 2'b10;
  localparam logic [1:0] OP_KILL  = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic             fail_q;
  logic             accept;
  logic             issue_fail;
  logic [TRD_W-1:0] alloc_base;
  logic [TRD_W-1:0] alloc_trd;
  logic             alloc_ok;

  assign req_ready  = (state == S_IDLE);
  assign accept     = req_valid & req_ready;
  // The CSR error responds combinationally to the bus, so it is sampled
  // while the pulse is out.
  assign issue_fail = fail_q | trd_error[cmd_obj_trd];

`ifdef THREAD_MGR_RR_ALLOC_EN
  logic [TRD_W-1:0] last_alloc;
  assign alloc_base = last_alloc;
`else
  // Searching from '1 + 1 wraps to 0, which gives lowest-free-index order.
  assign alloc_base = '1;
`endif

  // Free-thread search starting at alloc_base+1, wrapping modulo NUM_TRD.
  // The loop runs from the far end down, so the closest hit wins.
  always_comb begin
    logic [TRD_W-1:0] j;
    alloc_trd = '0;
    alloc_ok  = 1'b0;
    j         = '0;
    for (int k = NUM_TRD; k >= 1; k--) begin
      j = alloc_base + TRD_W'(k);
      if (!trd_valid[j]) begin
        alloc_trd = j;
        alloc_ok  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      op_q        <= OP_SPAWN;
      fail_q      <= 1'b0;
      cmd_init    <= 1'b0;
      cmd_slp     <= 1'b0;
      cmd_wake    <= 1'b0;
      cmd_kill    <= 1'b0;
      cmd_obj_trd <= '0;
      cmd_act_trd <= '0;
      cmd_pc      <= '0;
      rsp_valid   <= 1'b0;
      rsp_trd     <= '0;
      rsp_fail    <= 1'b0;
`ifdef THREAD_MGR_RR_ALLOC_EN
      last_alloc  <= '0;
`endif
    end else begin
      // Pulses default low, so each lasts exactly one cycle.
      cmd_init  <= 1'b0;
      cmd_slp   <= 1'b0;
      cmd_wake  <= 1'b0;
      cmd_kill  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_BOOT: begin
          cmd_init    <= 1'b1;
          cmd_obj_trd <= '0;
          cmd_act_trd <= '0;
          cmd_pc      <= START_PC;
          state       <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            // The payload registers double as the latched request, so the
            // command goes out in the very next cycle.
            op_q        <= req_op;
            cmd_act_trd <= req_act_trd;
            cmd_pc      <= req_pc;
            if (req_op == OP_SPAWN) begin
              cmd_obj_trd <= alloc_trd;
              fail_q      <= ~alloc_ok;
              cmd_init    <= alloc_ok;
            end else begin
              cmd_obj_trd <= req_obj_trd;
              fail_q      <= 1'b0;
              cmd_slp     <= (req_op == OP_SLP);
              cmd_wake    <= (req_op == OP_WAKE);
              cmd_kill    <= (req_op == OP_KILL);
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          fail_q    <= issue_fail;
          rsp_valid <= 1'b1;
          rsp_trd   <= cmd_obj_trd;
          rsp_fail  <= issue_fail;
`ifdef THREAD_MGR_RR_ALLOC_EN
          if (op_q == OP_SPAWN && !issue_fail)
            last_alloc <= cmd_obj_trd;
`endif
          state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Round-robin scheduler. The search visits cur_trd+1 up to cur_trd+NUM_TRD,
  // so cur_trd itself is tried last. With nothing eligible, cur_trd holds.
  logic [NUM_TRD-1:0] eligible;
  logic [TRD_W-1:0]   sched_nxt;

  assign eligible = trd_valid & trd_running;

  always_comb begin
    logic [TRD_W-1:0] j;
    sched_nxt = cur_trd;
    j         = '0;
    for (int k = NUM_TRD; k >= 1; k--) begin
      j = cur_trd + TRD_W'(k);
      if (eligible[j]) sched_nxt = j;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_trd <= '0;
      cur_vld <= 1'b0;
    end else begin
      cur_vld <= |eligible;
      if (sched_en) cur_trd <= sched_nxt;
    end
  end

endmodule

// File: tb/tb_thread_manager.sv
// Testbench for thread_manager. Stimulus pushes the expected command and
// response into queues. A negedge monitor pops the queues and compares them
// whenever the DUT shows a command pulse or rsp_valid. Reset, latency and
// scheduler behaviour are checked directly by the stimulus process.
module tb_thread_manager;
  localparam int          NUM_TRD  = 8;
  localparam int          TRD_W    = 3;
  localparam logic [31:0] START_PC = 32'h0000_0040;

  localparam logic [1:0] OP_SPAWN = 2'b00;
  localparam logic [1:0] OP_SLP   = 2'b01;
  localparam logic [1:0] OP_WAKE  = 2'b10;
  localparam logic [1:0] OP_KILL  = 2'b11;

  // Pulse encodings: {init, slp, wake, kill}.
  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_INIT = 4'b1000;
  localparam logic [3:0] P_SLP  = 4'b0100;
  localparam logic [3:0] P_WAKE = 4'b0010;
  localparam logic [3:0] P_KILL = 4'b0001;

  logic               clk, rst_n;
  logic               req_valid, req_ready;
  logic [1:0]         req_op;
  logic [TRD_W-1:0]   req_act_trd, req_obj_trd;
  logic [31:0]        req_pc;
  logic [NUM_TRD-1:0] trd_valid, trd_running, trd_error;
  logic               cmd_init, cmd_slp, cmd_wake, cmd_kill;
  logic [TRD_W-1:0]   cmd_obj_trd, cmd_act_trd;
  logic [31:0]        cmd_pc;
  logic               rsp_valid, rsp_fail;
  logic [TRD_W-1:0]   rsp_trd;
  logic               sched_en;
  logic [TRD_W-1:0]   cur_trd;
  logic               cur_vld;

  thread_manager #(.NUM_TRD(NUM_TRD), .TRD_W(TRD_W), .START_PC(START_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_act_trd(req_act_trd), .req_obj_trd(req_obj_trd), .req_pc(req_pc),
    .trd_valid(trd_valid), .trd_running(trd_running), .trd_error(trd_error),
    .cmd_init(cmd_init), .cmd_slp(cmd_slp), .cmd_wake(cmd_wake), .cmd_kill(cmd_kill),
    .cmd_obj_trd(cmd_obj_trd), .cmd_act_trd(cmd_act_trd), .cmd_pc(cmd_pc),
    .rsp_valid(rsp_valid), .rsp_trd(rsp_trd), .rsp_fail(rsp_fail),
    .sched_en(sched_en), .cur_trd(cur_trd), .cur_vld(cur_vld)
  );

  typedef struct packed {
    logic [3:0]       p;
    logic [TRD_W-1:0] obj;
    logic [TRD_W-1:0] act;
    logic [31:0]      pc;
  } cmd_t;

  typedef struct packed {
    logic [TRD_W-1:0] trd;
    logic             fail;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expectation queues whenever the DUT presents output.
  always @(negedge clk) begin : mon
    cmd_t g, e;
    rsp_t rg, re;
    g  = {cmd_init, cmd_slp, cmd_wake, cmd_kill, cmd_obj_trd, cmd_act_trd, cmd_pc};
    rg = {rsp_trd, rsp_fail};
    if (|g.p) begin
      chk("cmd_onehot", 64'($countones(g.p)), 64'd1);
      if (cmd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cmd_unexpected got=%0h exp=none", g);
      end else begin
        e = cmd_q.pop_front();
        chk("cmd_bus", 64'(g), 64'(e));
      end
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected got=%0h exp=none", rg);
      end else begin
        re = rsp_q.pop_front();
        chk("rsp", 64'(rg), 64'(re));
      end
    end
  end

  // One op: wait for ready, queue the expectations, then walk accept, ISSUE
  // and RESP. err is applied to trd_error during ISSUE only.
  task automatic do_req(input logic [1:0] op, input logic [TRD_W-1:0] act,
                        input logic [TRD_W-1:0] obj, input logic [31:0] pc,
                        input logic [3:0] ep, input logic [TRD_W-1:0] eobj,
                        input logic efail, input logic [NUM_TRD-1:0] err);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid   = 1'b1;
    req_op      = op;
    req_act_trd = act;
    req_obj_trd = obj;
    req_pc      = pc;
    if (ep != P_NONE) cmd_q.push_back(cmd_t'({ep, eobj, act, pc}));
    rsp_q.push_back(rsp_t'({eobj, efail}));
    tick();
    // Scramble the request fields: they only need to be held during accept.
    req_valid   = 1'b0;
    req_op      = 2'b11;
    req_act_trd = '1;
    req_obj_trd = '1;
    req_pc      = 32'hDEAD_BEEF;
    trd_error   = err;
    chk("issue_not_ready", 64'(req_ready), 64'd0);
    tick();
    trd_error = '0;
    tick();
    chk("ready_at_n3", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_op      = '0;
    req_act_trd = '0;
    req_obj_trd = '0;
    req_pc      = '0;
    trd_valid   = '0;
    trd_running = '0;
    trd_error   = '0;
    sched_en    = 1'b0;
    tick();
    tick();

    // Reset values.
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_cmd_bus", 64'({cmd_init, cmd_slp, cmd_wake, cmd_kill, cmd_obj_trd, cmd_act_trd, cmd_pc}), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_trd, rsp_fail}), 64'd0);
    chk("rst_sched", 64'({cur_trd, cur_vld}), 64'd0);

    // Boot: init of thread 0 at START_PC, then ready with no response.
    cmd_q.push_back(cmd_t'({P_INIT, 3'd0, 3'd0, START_PC}));
    rst_n = 1'b1;
    tick();
    tick();
    chk("boot_ready", 64'(req_ready), 64'd1);
    chk("boot_no_rsp", 64'(rsp_valid), 64'd0);
    chk("boot_init_one_cycle", 64'(cmd_init), 64'd0);

    // Spawn with thread 0 in use: allocates thread 1.
    trd_valid = 8'b0000_0001;
    do_req(OP_SPAWN, 3'd0, 3'd5, 32'h100, P_INIT, 3'd1, 1'b0, '0);
    // Spawn with every thread in use: no pulse; fails with thread 0.
    trd_valid = 8'hFF;
    do_req(OP_SPAWN, 3'd0, 3'd0, 32'h200, P_NONE, 3'd0, 1'b1, '0);
    // Kill with the CSR reporting an error on the target.
    do_req(OP_KILL, 3'd2, 3'd3, 32'h300, P_KILL, 3'd3, 1'b1, 8'h08);
    // Sleep with an error on a different thread: must not fail.
    do_req(OP_SLP, 3'd1, 3'd5, 32'h0, P_SLP, 3'd5, 1'b0, 8'h01);
    // Wake of an invalid thread: pulse issued, no failure reported.
    trd_valid = 8'hBF;
    do_req(OP_WAKE, 3'd0, 3'd6, 32'h44, P_WAKE, 3'd6, 1'b0, '0);
    // Spawn with threads 0..2 in use: thread 3 in both allocation modes.
    trd_valid = 8'b0000_0111;
    do_req(OP_SPAWN, 3'd4, 3'd0, 32'h400, P_INIT, 3'd3, 1'b0, '0);

    // Reset during ISSUE: pulse drops at once, no response, boot repeats.
    req_valid   = 1'b1;
    req_op      = OP_SLP;
    req_act_trd = 3'd1;
    req_obj_trd = 3'd2;
    req_pc      = 32'h500;
    tick();
    req_valid = 1'b0;
    chk("pre_reset_slp", 64'(cmd_slp), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_cmd", 64'({cmd_init, cmd_slp, cmd_wake, cmd_kill}), 64'd0);
    chk("reset_drops_rsp", 64'(rsp_valid), 64'd0);
    chk("reset_ready_low", 64'(req_ready), 64'd0);
    tick();
    tick();
    cmd_q.push_back(cmd_t'({P_INIT, 3'd0, 3'd0, START_PC}));
    rst_n = 1'b1;
    tick();
    tick();
    chk("reboot_ready", 64'(req_ready), 64'd1);

    // Two spawns after reset with only thread 0 in use.
    trd_valid = 8'b0000_0001;
    do_req(OP_SPAWN, 3'd0, 3'd0, 32'h600, P_INIT, 3'd1, 1'b0, '0);
`ifdef THREAD_MGR_RR_ALLOC_EN
    do_req(OP_SPAWN, 3'd0, 3'd0, 32'h700, P_INIT, 3'd2, 1'b0, '0);
`else
    do_req(OP_SPAWN, 3'd0, 3'd0, 32'h700, P_INIT, 3'd1, 1'b0, '0);
`endif

    // Scheduler: eligible = {7,4,1}. The first step from 0 lands on 1.
    trd_valid   = 8'b1001_0010;
    trd_running = 8'hFF;
    sched_en    = 1'b1;
    tick();
    chk("sched_start", 64'({cur_trd, cur_vld}), 64'({3'd1, 1'b1}));
    tick();
    chk("sched_4", 64'(cur_trd), 64'd4);
    tick();
    chk("sched_7", 64'(cur_trd), 64'd7);
    tick();
    chk("sched_wrap_1", 64'(cur_trd), 64'd1);
    tick();
    chk("sched_4b", 64'(cur_trd), 64'd4);
    trd_running = '0;
    tick();
    chk("sched_none", 64'({cur_trd, cur_vld}), 64'({3'd4, 1'b0}));
    // Scheduler disabled: cur_trd holds even though it is not eligible.
    sched_en    = 1'b0;
    trd_running = 8'hFF;
    trd_valid   = 8'b0000_0001;
    tick();
    chk("sched_hold", 64'({cur_trd, cur_vld}), 64'({3'd4, 1'b1}));

    tick();
    tick();
    chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thread_manager.md
Name: thread_manager

Overview:
- Central thread-control issuer. It drives the shared command bus (init/slp/wake/kill, obj_trd, act_trd, init_pc) into the per-thread CSRs and reads back their valid/running/error vectors.
- Serialises thread-op requests from execute and allocates a free thread ID on spawn.
- Boots thread 0 out of reset.
- Runs the round-robin scheduler that picks the current thread for fetch.

Parameters:
- NUM_TRD, 8, number of hardware threads (power of 2, ≤ 8).
- TRD_W, 3, thread ID width, equal to clog2(NUM_TRD).
- START_PC, 32'h0000_0000, init_pc used for the boot of thread 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  thread-op request valid
- req_ready  out  1  manager can accept a request
- req_op  in  2  request op: 00 spawn, 01 sleep, 10 wake, 11 kill
- req_act_trd  in  TRD_W  requesting (action) thread
- req_obj_trd  in  TRD_W  target thread; ignored for spawn
- req_pc  in  32  start PC for spawn
- trd_valid  in  NUM_TRD  valid bits from the CSRs
- trd_running  in  NUM_TRD  running bits from the CSRs
- trd_error  in  NUM_TRD  combinational error bits from the CSRs
- cmd_init  out  1  init pulse
- cmd_slp  out  1  sleep pulse
- cmd_wake  out  1  wake pulse
- cmd_kill  out  1  kill pulse
- cmd_obj_trd  out  TRD_W  objective thread on the command bus
- cmd_act_trd  out  TRD_W  action thread on the command bus
- cmd_pc  out  32  init_pc on the command bus
- rsp_valid  out  1  one-cycle completion pulse
- rsp_trd  out  TRD_W  thread ID of the completed op (allocated ID for spawn)
- rsp_fail  out  1  op failed
- sched_en  in  1  advance the scheduler this cycle
- cur_trd  out  TRD_W  currently scheduled thread
- cur_vld  out  1  cur_trd is runnable

Behaviour:
- Reset values: FSM in BOOT; req_ready=0; all cmd_* = 0; rsp_valid=0; rsp_fail=0; rsp_trd=0; cur_trd=0; cur_vld=0.
- Command pulses are registered and one-hot; at most one of init/slp/wake/kill is high in any cycle, and each lasts exactly one cycle.
- FSM states: BOOT, IDLE, ISSUE, RESP.
- BOOT (first cycle after reset release):
  - Drives cmd_init=1, cmd_obj_trd=0, cmd_act_trd=0, cmd_pc=START_PC.
  - Next state is IDLE. No rsp is generated.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch op/act/obj/pc and go to ISSUE.
- Spawn allocation in IDLE: pick the lowest-index thread with trd_valid==0 and latch it as obj.
  - If none is free, set the latched fail flag; ISSUE emits no pulse.
- ISSUE:
  - req_ready=0.
  - Unless fail is already set, drive the matching cmd_* pulse with the latched obj/act/pc.
  - Same cycle: fail |= trd_error[obj] (the CSR error is combinational on the bus).
  - Next state is RESP.
- RESP:
  - rsp_valid=1, rsp_trd=obj, rsp_fail=fail.
  - Next state is IDLE.
- Latency: request accepted at cycle N, command at N+1, rsp_valid at N+2, req_ready high again at N+3. Throughput is one op per 3 cycles.
- CSR state checks are left to the CSR; the manager only reports trd_error. A wake of an invalid thread is a no-op in the CSR and is reported with rsp_fail=0.
- Scheduler:
  - eligible = trd_valid & trd_running.
  - When sched_en=1, cur_trd becomes the first eligible index after cur_trd in ascending modulo-NUM_TRD order. The search includes cur_trd itself last.
  - cur_vld is registered as |eligible and updates every cycle regardless of sched_en.
  - If nothing is eligible, cur_trd holds.
  - When sched_en=0, cur_trd holds even if it is no longer eligible; cur_vld still reflects |eligible.
- Reset asserted mid-operation: immediate return to reset values and BOOT; any in-flight request is dropped with no rsp.
- Request fields only need to be stable in the accepting cycle.

Optional Feature:
- Macro: THREAD_MGR_RR_ALLOC_EN.
- Defined: spawn allocation is round-robin. The search starts at (last allocated ID + 1) mod NUM_TRD and takes the first free thread. The last-allocated pointer resets to 0 and updates only on successful spawns.
- Undefined: lowest-free-index allocation, and the pointer register is not present.

Test Plan:
- Reset release, all trd_valid=0 -> cycle 1: cmd_init=1, cmd_obj_trd=0, cmd_act_trd=0, cmd_pc=START_PC; cycle 2: req_ready=1, no rsp_valid.
- trd_valid=8'b0000_0001, spawn req act=0 pc=32'h100 -> next cycle cmd_init=1, obj=1, act=0, cmd_pc=32'h100; cycle after: rsp_valid=1, rsp_trd=1, rsp_fail=0.
- trd_valid=8'hFF, spawn -> no cmd pulse in ISSUE; RESP gives rsp_fail=1, rsp_trd=0.
- Kill obj=3 act=2 with trd_error[3]=1 during ISSUE -> cmd_kill=1, obj=3, act=2; rsp_fail=1, rsp_trd=3.
- eligible=8'b1001_0010, cur_trd=1, sched_en held high -> cur_trd sequence 4, 7, 1, 4; eligible=0 -> cur_vld=0 next cycle, cur_trd holds.
- rst_n pulsed low during ISSUE -> cmd pulses and rsp_valid drop immediately; after release the BOOT init occurs again. With THREAD_MGR_RR_ALLOC_EN defined: two spawns with trd_valid=8'b0000_0001 return 1, then 2.
